// File: rtl/lsu_master.sv
// lsu_master: RISC-V load/store unit that drives a byte-addressed data memory.
// It takes one load/store per handshake and performs aligned accesses in one
// memory cycle. Misaligned halfword/word accesses are either split into
// sequential byte accesses or rejected with resp_error, depending on
// SPLIT_MISALIGNED. Load data is sign- or zero-extended before it is returned.
module lsu_master #(
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic        mem_read_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    output logic [1:0]  mem_access_size,
    input  logic [31:0] mem_data_out
);

    typedef enum logic [1:0] {IDLE, ACCESS, SPLIT, RESP} state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // Request latched at accept.
    state_t      state_q;
    logic        store_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    // Split bookkeeping: current byte index, index of the final byte, and the
    // load bytes gathered so far.
    logic [1:0]  byte_cnt_q;
    logic [1:0]  last_byte_q;
    logic [31:0] asm_q;

    // Registered response.
    logic        resp_valid_q;
    logic        resp_error_q;
    logic [31:0] resp_rdata_q;

    logic        req_illegal;
    logic        req_misaligned;
    logic [4:0]  lane_sel;
    logic [31:0] asm_d;
    logic        mem_write_raw;

    // Sign/zero extension selected by the load funct3. Bits of the raw value
    // above the access size are ignored.
    function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [31:0] raw);
        logic [31:0] ext;
        case (f3)
            3'b000:  ext = {{24{raw[7]}}, raw[7:0]};
            3'b001:  ext = {{16{raw[15]}}, raw[15:0]};
            3'b100:  ext = {24'd0, raw[7:0]};
            3'b101:  ext = {16'd0, raw[15:0]};
            default: ext = raw;
        endcase
        return ext;
    endfunction

    // Classify the incoming request: illegal funct3 and natural-alignment check.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned and no latch is inferred.
        req_illegal    = 1'b0;
        req_misaligned = 1'b0;
        if (req_store) begin
            // A store size of 11 has no defined memory access, so it is
            // rejected together with funct3[2]=1.
            req_illegal = req_funct3[2] || (req_funct3[1:0] == 2'b11);
        end else begin
            req_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
        end
        case (req_funct3[1:0])
            SIZE_HALF: req_misaligned = req_addr[0];
            SIZE_WORD: req_misaligned = (req_addr[1:0] != 2'b00);
            default:   req_misaligned = 1'b0;
        endcase
    end

    // Merge the byte returned in the current split cycle into the load assembly.
    always_comb begin
        lane_sel               = {byte_cnt_q, 3'b000};
        asm_d                  = asm_q;
        asm_d[lane_sel +: 8]   = mem_data_out[7:0];
    end

    // Memory-side outputs decoded from the state; idle values outside a memory cycle.
    always_comb begin
        mem_write_raw   = 1'b0;
        mem_address     = 32'd0;
        mem_data_in     = 32'd0;
        mem_access_size = SIZE_WORD;
        case (state_q)
            ACCESS: begin
                mem_write_raw   = store_q;
                mem_address     = addr_q;
                mem_data_in     = wdata_q;
                mem_access_size = funct3_q[1:0];
            end
            SPLIT: begin
                mem_write_raw   = store_q;
                mem_address     = addr_q + {30'd0, byte_cnt_q};
                mem_data_in     = {24'd0, wdata_q[lane_sel +: 8]};
                mem_access_size = SIZE_BYTE;
            end
            default: begin
                mem_write_raw   = 1'b0;
            end
        endcase
    end

    // Gating with reset_n keeps the memory from writing on an edge that resets the LSU.
    assign mem_read_write = mem_write_raw & reset_n;

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_error = resp_error_q;

    // Control FSM: accept, one aligned access or N byte accesses, one response cycle.
    always_ff @(posedge clock) begin
        // NOTE: state registers use non-blocking assignments so every register
        // in this block samples the pre-edge values, independent of order.
        if (!reset_n) begin
            state_q      <= IDLE;
            store_q      <= 1'b0;
            funct3_q     <= 3'd0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            byte_cnt_q   <= 2'd0;
            last_byte_q  <= 2'd0;
            asm_q        <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            resp_rdata_q <= 32'd0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        store_q     <= req_store;
                        funct3_q    <= req_funct3;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        byte_cnt_q  <= 2'd0;
                        last_byte_q <= (req_funct3[1:0] == SIZE_HALF) ? 2'd1 : 2'd3;
                        asm_q       <= 32'd0;
                        if (req_illegal || (req_misaligned && !SPLIT_MISALIGNED)) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_error_q <= 1'b1;
                            resp_rdata_q <= 32'd0;
                        end else if (req_misaligned) begin
                            state_q <= SPLIT;
                        end else begin
                            state_q <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    state_q      <= RESP;
                    resp_valid_q <= 1'b1;
                    resp_error_q <= 1'b0;
                    resp_rdata_q <= store_q ? 32'd0 : extend_load(funct3_q, mem_data_out);
                end
                SPLIT: begin
                    asm_q <= asm_d;
                    if (byte_cnt_q == last_byte_q) begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_error_q <= 1'b0;
                        resp_rdata_q <= store_q ? 32'd0 : extend_load(funct3_q, asm_d);
                    end else begin
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_master.sv
// tb_lsu_master: randomized and directed stimulus for lsu_master with a
// scoreboard. The driver pushes expected memory beats and responses computed
// by a byte-level reference model; a monitor pops and compares whenever the
// DUT shows a memory cycle or a response. A second instance with
// SPLIT_MISALIGNED=0 is exercised with a few directed loads.
module tb_lsu_master;

    typedef struct packed {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
    } beat_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [31:0] due;
    } resp_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    // Main DUT (splitting enabled)
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        mem_read_write;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic [1:0]  mem_access_size;
    logic [31:0] mem_data_out;

    // Second DUT (splitting disabled), fixed memory read data
    logic        req_valid0 = 1'b0;
    logic        req_ready0;
    logic        req_store0 = 1'b0;
    logic [2:0]  req_funct3_0 = 3'd0;
    logic [31:0] req_addr0 = 32'd0;
    logic [31:0] req_wdata0 = 32'd0;
    logic        resp_valid0;
    logic [31:0] resp_rdata0;
    logic        resp_error0;
    logic        mem_read_write0;
    logic [31:0] mem_address0;
    logic [31:0] mem_data_in0;
    logic [1:0]  mem_access_size0;
    logic [31:0] mem_data_out0;
    assign mem_data_out0 = 32'h1234_8001;

    lsu_master #(.SPLIT_MISALIGNED(1'b1)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
        .mem_read_write(mem_read_write), .mem_address(mem_address),
        .mem_data_in(mem_data_in), .mem_access_size(mem_access_size),
        .mem_data_out(mem_data_out)
    );

    lsu_master #(.SPLIT_MISALIGNED(1'b0)) dut0 (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_store(req_store0),
        .req_funct3(req_funct3_0), .req_addr(req_addr0), .req_wdata(req_wdata0),
        .resp_valid(resp_valid0), .resp_rdata(resp_rdata0), .resp_error(resp_error0),
        .mem_read_write(mem_read_write0), .mem_address(mem_address0),
        .mem_data_in(mem_data_in0), .mem_access_size(mem_access_size0),
        .mem_data_out(mem_data_out0)
    );

    // 256-byte memory, aliased on address bits [7:0]; combinational read,
    // byte-lane write at posedge.
    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];
    logic [7:0] ma, ma1, ma2, ma3;
    assign ma  = mem_address[7:0];
    assign ma1 = ma + 8'd1;
    assign ma2 = ma + 8'd2;
    assign ma3 = ma + 8'd3;
    assign mem_data_out = {mem[ma3], mem[ma2], mem[ma1], mem[ma]};

    always @(posedge clock) begin
        if (mem_read_write === 1'b1) begin
            mem[ma] <= mem_data_in[7:0];
            if (mem_access_size != 2'b00) mem[ma1] <= mem_data_in[15:8];
            if (mem_access_size == 2'b10) begin
                mem[ma2] <= mem_data_in[23:16];
                mem[ma3] <= mem_data_in[31:24];
            end
        end
    end

    logic [31:0] cyc = 32'd0;
    always @(posedge clock) cyc <= cyc + 32'd1;

    int    vectors = 0;
    int    miscompares = 0;
    bit    started = 1'b0;
    beat_t beat_q[$];
    resp_t resp_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference model: derives memory beats, response and memory effect from
    // the request using byte arithmetic on ref_mem. acc is the accept edge.
    task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] acc);
        int          n;
        bit          illegal;
        bit          mis;
        logic [31:0] val;
        beat_t       b;
        resp_t       r;
        n       = (f3[1:0] == 2'd0) ? 1 : ((f3[1:0] == 2'd1) ? 2 : 4);
        illegal = st ? (f3 >= 3'd4) : (f3 == 3'd3 || f3 >= 3'd6);
        mis     = (a % 32'(n)) != 32'd0;
        r.rdata = 32'd0;
        r.err   = 1'b0;
        if (illegal) begin
            r.err = 1'b1;
            r.due = acc;
            resp_q.push_back(r);
            return;
        end
        if (!mis) begin
            b.rw = st; b.addr = a; b.data = wd; b.size = f3[1:0];
            beat_q.push_back(b);
            r.due = acc + 32'd1;
        end else begin
            for (int k = 0; k < n; k++) begin
                b.rw = st; b.addr = a + 32'(k); b.size = 2'b00;
                b.data = (wd >> (8 * k)) & 32'hFF;
                beat_q.push_back(b);
            end
            r.due = acc + 32'(n);
        end
        if (st) begin
            for (int k = 0; k < n; k++) ref_mem[8'(a + 32'(k))] = 8'(wd >> (8 * k));
        end else begin
            val = 32'd0;
            for (int k = 0; k < n; k++) val = val | (32'(ref_mem[8'(a + 32'(k))]) << (8 * k));
            if (f3 == 3'd0 && val >= 32'd128)   val = val - 32'd256;
            if (f3 == 3'd1 && val >= 32'd32768) val = val - 32'd65536;
            r.rdata = val;
        end
        resp_q.push_back(r);
    endtask

    // Monitor: compare each visible memory cycle and each response.
    always @(negedge clock) begin
        beat_t e;
        resp_t rr;
        if (started) begin
            if (mem_read_write !== 1'b0 || mem_access_size !== 2'b10 ||
                mem_address !== 32'd0 || mem_data_in !== 32'd0) begin
                if (beat_q.size() == 0) begin
                    check("unexpected_mem_cycle", mem_address, 32'hFFFF_FFFF);
                end else begin
                    e = beat_q.pop_front();
                    check("mem_read_write", 32'(mem_read_write), 32'(e.rw));
                    check("mem_address", mem_address, e.addr);
                    check("mem_access_size", 32'(mem_access_size), 32'(e.size));
                    check("mem_data_in", mem_data_in, e.data);
                end
            end
            if (resp_valid !== 1'b0) begin
                if (resp_q.size() == 0) begin
                    check("unexpected_resp", 32'(resp_valid), 32'd0);
                end else begin
                    rr = resp_q.pop_front();
                    check("resp_rdata", resp_rdata, rr.rdata);
                    check("resp_error", 32'(resp_error), 32'(rr.err));
                    check("resp_cycle", cyc, rr.due);
                end
            end
        end
    end

    task automatic wait_ready(output bit ok);
        int guard;
        guard = 0;
        while (req_ready !== 1'b1 && guard < 50) begin
            @(posedge clock); #1;
            guard++;
        end
        ok = (req_ready === 1'b1);
        if (!ok) check("req_ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        bit ok;
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        wait_ready(ok);
        if (!ok) begin
            req_valid = 1'b0;
            return;
        end
        model(st, f3, a, wd, cyc + 32'd1);
        @(posedge clock); #1;
        req_valid  = 1'b0;
        req_store  = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((beat_q.size() != 0 || resp_q.size() != 0) && guard < 100) begin
            @(posedge clock); #1;
            guard++;
        end
        check("pending_expectations", 32'(beat_q.size() + resp_q.size()), 32'd0);
        beat_q.delete();
        resp_q.delete();
    endtask

    // Directed load on the non-splitting instance; lat is the response latency.
    task automatic run0(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] exp_rdata,
                        input logic exp_err, input int lat);
        int          guard;
        int          seen;
        bit          mem_seen;
        logic [31:0] acc;
        guard = 0; seen = 0; mem_seen = 1'b0;
        req_valid0 = 1'b1; req_store0 = 1'b0; req_funct3_0 = f3; req_addr0 = a; req_wdata0 = $urandom;
        while (req_ready0 !== 1'b1 && guard < 20) begin
            @(posedge clock); #1;
            guard++;
        end
        if (req_ready0 !== 1'b1) begin
            check("dut0_ready_timeout", 32'd0, 32'd1);
            req_valid0 = 1'b0;
            return;
        end
        @(posedge clock); #1;
        req_valid0 = 1'b0;
        acc = cyc;
        for (int t = 0; t < 4; t++) begin
            @(negedge clock);
            if (mem_read_write0 !== 1'b0 || mem_access_size0 !== 2'b10 || mem_address0 !== 32'd0) mem_seen = 1'b1;
            if (resp_valid0 !== 1'b0) begin
                seen++;
                check("dut0_resp_rdata", resp_rdata0, exp_rdata);
                check("dut0_resp_error", 32'(resp_error0), 32'(exp_err));
                check("dut0_resp_cycle", cyc, acc + 32'(lat) - 32'd1);
            end
        end
        check("dut0_resp_count", 32'(seen), 32'd1);
        if (exp_err) check("dut0_mem_activity", 32'(mem_seen), 32'd0);
        @(posedge clock); #1;
    endtask

    logic [2:0] ld_ok  [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic [2:0] ld_bad [3] = '{3'd3, 3'd6, 3'd7};

    initial begin
        bit          ok;
        int          bad;
        beat_t       b;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] base;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'd0;
            ref_mem[i] = 8'd0;
        end
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        started = 1'b1;

        // Reset state
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_error", 32'(resp_error), 32'd0);
        check("rst_mem_read_write", 32'(mem_read_write), 32'd0);
        check("rst_mem_address", mem_address, 32'd0);
        check("rst_mem_data_in", mem_data_in, 32'd0);
        check("rst_mem_access_size", 32'(mem_access_size), 32'd2);
        check("rst_dut0_req_ready", 32'(req_ready0), 32'd1);

        // Non-splitting instance: misaligned -> error, aligned -> normal
        run0(3'b001, 32'h0100_0041, 32'd0, 1'b1, 1);
        run0(3'b101, 32'h0100_0043, 32'd0, 1'b1, 1);
        run0(3'b010, 32'h0100_0040, 32'h1234_8001, 1'b0, 2);
        run0(3'b001, 32'h0100_0040, 32'hFFFF_8001, 1'b0, 2);

        // Aligned store then load, response data held afterwards
        issue(1'b1, 3'b010, 32'h0100_0010, 32'hDEAD_BEEF);
        issue(1'b0, 3'b010, 32'h0100_0010, $urandom);
        drain();
        repeat (2) @(posedge clock);
        #1;
        check("resp_rdata_held", resp_rdata, 32'hDEAD_BEEF);

        // Extension of byte/half loads
        issue(1'b1, 3'b010, 32'h0100_0020, 32'h0000_80F0);
        issue(1'b0, 3'b000, 32'h0100_0020, $urandom);
        issue(1'b0, 3'b100, 32'h0100_0020, $urandom);
        issue(1'b0, 3'b001, 32'h0100_0020, $urandom);
        issue(1'b0, 3'b101, 32'h0100_0020, $urandom);

        // Split store / load
        issue(1'b1, 3'b010, 32'h0100_0031, 32'h1122_3344);
        issue(1'b0, 3'b010, 32'h0100_0031, $urandom);

        // Illegal encodings
        issue(1'b0, 3'b011, 32'h0100_0010, $urandom);
        issue(1'b1, 3'b100, 32'h0100_0010, $urandom);

        // Split halfword load with sign bit clear in the upper byte
        issue(1'b1, 3'b000, 32'h0100_0041, 32'h0000_0080);
        issue(1'b1, 3'b000, 32'h0100_0042, 32'h0000_007F);
        issue(1'b0, 3'b001, 32'h0100_0041, $urandom);

        // Address wrap across 2^32 during a split
        issue(1'b1, 3'b010, 32'hFFFF_FFFE, 32'hCAFE_F00D);
        issue(1'b0, 3'b010, 32'hFFFF_FFFE, $urandom);
        drain();

        // Reset during byte 2 of a split store
        issue(1'b1, 3'b010, 32'h0100_0050, 32'd0);
        issue(1'b1, 3'b010, 32'h0100_0054, 32'd0);
        drain();
        a = 32'h0100_0051;
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010; req_addr = a; req_wdata = 32'hAABB_CCDD;
        wait_ready(ok);
        if (ok) begin
            b.rw = 1'b1; b.size = 2'b00;
            b.addr = a;          b.data = 32'hDD; beat_q.push_back(b);
            b.addr = a + 32'd1;  b.data = 32'hCC; beat_q.push_back(b);
            b.rw = 1'b0;
            b.addr = a + 32'd2;  b.data = 32'hBB; beat_q.push_back(b);
            ref_mem[8'h51] = 8'hDD;
            ref_mem[8'h52] = 8'hCC;
            @(posedge clock); #1;
            req_valid = 1'b0;
            @(posedge clock); #1;
            @(posedge clock); #1;
            reset_n = 1'b0;
            @(posedge clock); #1;
            reset_n = 1'b1;
            check("abort_req_ready", 32'(req_ready), 32'd1);
            check("abort_resp_rdata", resp_rdata, 32'd0);
        end else begin
            req_valid = 1'b0;
        end
        issue(1'b0, 3'b010, 32'h0100_0051, $urandom);
        drain();

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            st   = 1'($urandom);
            base = ($urandom_range(0, 1) == 0) ? 32'h0100_0000 : 32'hFFFF_FF00;
            a    = base | 32'($urandom_range(0, 255));
            if (st) f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 2));
            else    f3 = ($urandom_range(0, 9) == 0) ? ld_bad[$urandom_range(0, 2)] : ld_ok[$urandom_range(0, 4)];
            issue(st, f3, a, $urandom);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clock); #1;
                end
            end
        end
        drain();

        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
        check("mem_image_bad_bytes", 32'(bad), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
